// File: rtl/nexys_starship_pkg.sv
// Shared types and constants for the starship hazard logic: break-gen state codes, LFSR taps, subsystem slots.
package nexys_starship_pkg;

  typedef enum logic [3:0] {
    BG_IDLE  = 4'b0001,
    BG_LOAD  = 4'b0010,
    BG_COUNT = 4'b0100,
    BG_FIRE  = 4'b1000
  } bg_state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam int SYS_TR = 0;
  localparam int SYS_TL = 1;
  localparam int SYS_BR = 2;
  localparam int SYS_BL = 3;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advances every cycle; output is the register itself (0 latency).
// No backpressure; a zero seed is swapped for the default so the sequence never locks up.
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] seed_eff;

  assign seed_eff = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) lfsr_q <= seed_eff;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/nexys_starship_break_gen.sv
// Random one-hot break pulses + repair hex for the repair stages; pulse/hex register one cycle after FIRE.
// No backpressure: broken is sampled only in FIRE. NEXYS_STARSHIP_DIFFICULTY_RAMP_EN enables the gap ramp.
module nexys_starship_break_gen
  import nexys_starship_pkg::*;
#(
  parameter int          NUM_SYS    = 4,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [24:0] TICK_DIV   = 25'd25_000_000,
  parameter logic [7:0]  MIN_GAP    = 8'd3,
  parameter logic [3:0]  RAMP_EVERY = 4'd4,
  parameter logic [7:0]  GAP_FLOOR  = 8'd1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               play_flag,
  input  logic               gameover_ctrl,
  input  logic [NUM_SYS-1:0] broken,
  output logic [NUM_SYS-1:0] break_pulse,
  output logic [3:0]         random_hex,
  output logic               q_BG_Idle,
  output logic               q_BG_Load,
  output logic               q_BG_Count,
  output logic               q_BG_Fire
);

  localparam logic [24:0] TICK_LAST = (TICK_DIV > 25'd1) ? (TICK_DIV - 25'd1) : 25'd0;

  bg_state_e          state_q, state_d;
  logic [24:0]        prescaler_q, prescaler_d;
  logic [7:0]         timer_q, timer_d;
  logic [NUM_SYS-1:0] pulse_q, pulse_d;
  logic [3:0]         hex_q, hex_d;
  logic [15:0]        lfsr;
  logic [7:0]         gap;
  logic [8:0]         load_sum;
  logic               tick;
  logic               found;
  logic               fire_ok;
  logic [NUM_SYS-1:0] slot_oh;
  logic               unused_lfsr;

  nexys_starship_lfsr16 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .seed  (SEED),
    .q     (lfsr)
  );

  assign unused_lfsr = ^lfsr[11:6];
  assign tick        = (prescaler_q == TICK_LAST);
  assign load_sum    = {1'b0, gap} + {3'b000, lfsr[5:0]};
  assign fire_ok     = (state_q == BG_FIRE) && found && !gameover_ctrl;

  // First free slot at or after the LFSR-chosen start index, wrapping around.
  always_comb begin : slot_scan
    int idx;
    int s;
    found   = 1'b0;
    slot_oh = '0;
    idx     = int'(lfsr[2:0]);
    if (idx >= NUM_SYS) idx = idx - NUM_SYS;
    for (int k = 0; k < NUM_SYS; k++) begin
      s = (idx + k) % NUM_SYS;
      for (int j = 0; j < NUM_SYS; j++) begin
        if (!found && (s == j) && !broken[j]) begin
          found      = 1'b1;
          slot_oh[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= BG_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (gameover_ctrl) begin
      state_d = BG_IDLE;
    end else begin
      case (state_q)
        BG_IDLE:  if (play_flag) state_d = BG_LOAD;
        BG_LOAD:  state_d = BG_COUNT;
        BG_COUNT: if (tick && (timer_q == 8'd0)) state_d = BG_FIRE;
        BG_FIRE:  state_d = BG_LOAD;
        default:  state_d = BG_IDLE;
      endcase
    end
  end

  always_comb begin
    prescaler_d = prescaler_q;
    timer_d     = timer_q;
    pulse_d     = '0;
    hex_d       = hex_q;
    case (state_q)
      BG_LOAD: begin
        timer_d     = load_sum[8] ? 8'hFF : load_sum[7:0];
        prescaler_d = '0;
      end
      BG_COUNT: begin
        prescaler_d = tick ? 25'd0 : (prescaler_q + 25'd1);
        if (tick && (timer_q != 8'd0)) timer_d = timer_q - 8'd1;
      end
      BG_FIRE: begin
        if (fire_ok) begin
          pulse_d = slot_oh;
          hex_d   = lfsr[15:12];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prescaler_q <= '0;
      timer_q     <= '0;
      pulse_q     <= '0;
      hex_q       <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      timer_q     <= timer_d;
      pulse_q     <= pulse_d;
      hex_q       <= hex_d;
    end
  end

`ifdef NEXYS_STARSHIP_DIFFICULTY_RAMP_EN
  logic [7:0] gap_q, gap_d;
  logic [3:0] fire_cnt_q, fire_cnt_d;

  // fire_cnt wraps every RAMP_EVERY successful fires; each wrap shaves one tick off the gap.
  always_comb begin
    gap_d      = gap_q;
    fire_cnt_d = fire_cnt_q;
    if (state_d == BG_IDLE) begin
      gap_d      = MIN_GAP;
      fire_cnt_d = '0;
    end else if (fire_ok) begin
      if (fire_cnt_q >= (RAMP_EVERY - 4'd1)) begin
        fire_cnt_d = '0;
        if (gap_q > GAP_FLOOR) gap_d = gap_q - 8'd1;
      end else begin
        fire_cnt_d = fire_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      gap_q      <= MIN_GAP;
      fire_cnt_q <= '0;
    end else begin
      gap_q      <= gap_d;
      fire_cnt_q <= fire_cnt_d;
    end
  end

  assign gap = gap_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{RAMP_EVERY, GAP_FLOOR};
  assign gap        = MIN_GAP;
`endif

  assign break_pulse = pulse_q;
  assign random_hex  = hex_q;
  assign q_BG_Idle   = (state_q == BG_IDLE);
  assign q_BG_Load   = (state_q == BG_LOAD);
  assign q_BG_Count  = (state_q == BG_COUNT);
  assign q_BG_Fire   = (state_q == BG_FIRE);

endmodule
